// File: rtl/vga_timing_decoder.sv
// vga_timing_decoder: recovers raster position, pixel strobe and line/frame markers from sampled VGA syncs.
// Ports: clk/rst (async active-high); h_sync/v_sync/red/green/blue sampled inputs;
// pixel_valid/x/y/pix_r/pix_g/pix_b visible pixel two cycles after its sample; line_start/frame_start
// pulses at (0,y)/(0,0); locked when timing matches; h_err/v_err violation pulses;
// frame_sum previous-frame colour sum when VGA_DEC_CHECKSUM_EN is defined, else 0.
module vga_timing_decoder #(
  parameter int   H_VISIBLE   = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_VISIBLE   = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter logic SYNC_POL    = 1'b0,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  output logic        pixel_valid,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b,
  output logic        line_start,
  output logic        frame_start,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic [31:0] frame_sum
);
  localparam logic [11:0] HT  = 12'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
  localparam logic [11:0] VT  = 12'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
  localparam logic [11:0] HT1 = HT - 12'd1;
  localparam logic [11:0] VT1 = VT - 12'd1;
  localparam logic [11:0] HX0 = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] HX1 = 12'(H_SYNC + H_BACK + H_VISIBLE);
  localparam logic [11:0] VY0 = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] VY1 = 12'(V_SYNC + V_BACK + V_VISIBLE);
  localparam logic [1:0] SEARCH = 2'd0, TRACK = 2'd1, LOCKED = 2'd2;
  // hs_q/vs_q hold "sync asserted" for the stage-1 sample, hs_p/vs_p for the one before it
  logic hs_q, vs_q, hs_p, vs_p;
  logic [7:0] r_q, g_q, b_q;
  logic [11:0] h_cnt, v_cnt, h_nxt, v_nxt;
  logic v_pend;
  logic [1:0] state, state_nxt;
  logic [7:0] good, good_nxt;
  logic h_edge, v_edge, chk, h_bad, v_bad, pv_nxt, ls_nxt, fs_nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {hs_q, vs_q, hs_p, vs_p} <= '0;
      {r_q, g_q, b_q} <= '0;
    end else begin
      hs_q <= h_sync == SYNC_POL;
      vs_q <= v_sync == SYNC_POL;
      hs_p <= hs_q;
      vs_p <= vs_q;
      {r_q, g_q, b_q} <= {red, green, blue};
    end
  always_comb begin
    h_edge = hs_q & ~hs_p;
    v_edge = vs_q & ~vs_p;
    h_nxt = h_edge ? '0 : h_cnt + 12'(h_cnt != HT);
    v_nxt = !h_edge ? v_cnt : (v_pend | v_edge) ? '0 : v_cnt + 12'(v_cnt != VT);
    chk = state != SEARCH;
    // h_cnt == HT1 without an edge means this sample pushes the count to HT
    h_bad = chk & (h_edge ? h_cnt != HT1 : h_cnt == HT1);
    // v_cnt still holds the line the v edge arrived on, even when it coincides with an h edge
    v_bad = chk & ((v_edge & (v_cnt != VT1)) | (h_edge & ~v_pend & ~v_edge & (v_cnt == VT1)));
    state_nxt = state == SEARCH ? (v_edge ? TRACK : SEARCH) :
                (h_bad | v_bad) ? SEARCH :
                (state == TRACK && v_edge && good + 8'd1 == 8'(LOCK_FRAMES)) ? LOCKED : state;
    good_nxt = state == TRACK ? good + 8'(v_edge) : '0;
    pv_nxt = state_nxt == LOCKED && h_nxt >= HX0 && h_nxt < HX1 && v_nxt >= VY0 && v_nxt < VY1;
    ls_nxt = pv_nxt && h_nxt == HX0;
    fs_nxt = ls_nxt && v_nxt == VY0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {h_cnt, v_cnt, v_pend, state, good} <= '0;
      {pixel_valid, line_start, frame_start, h_err, v_err} <= '0;
      {x, y, pix_r, pix_g, pix_b} <= '0;
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      v_pend <= h_edge ? 1'b0 : v_pend | v_edge;
      state <= state_nxt;
      good <= good_nxt;
      pixel_valid <= pv_nxt;
      line_start <= ls_nxt;
      frame_start <= fs_nxt;
      h_err <= h_bad;
      v_err <= v_bad;
      if (pv_nxt) begin
        x <= 10'(h_nxt - HX0);
        y <= 10'(v_nxt - VY0);
        {pix_r, pix_g, pix_b} <= {r_q, g_q, b_q};
      end
    end
  assign locked = state == LOCKED;
`ifdef VGA_DEC_CHECKSUM_EN
  logic [31:0] acc;
  logic full;
  // full marks that acc started at a frame_start, so only whole locked frames are published
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {acc, full, frame_sum} <= '0;
    end else if (state_nxt != LOCKED) begin
      acc <= '0;
      full <= 1'b0;
    end else if (fs_nxt) begin
      acc <= {8'd0, r_q, g_q, b_q};
      full <= 1'b1;
      if (full) frame_sum <= acc;
    end else if (pv_nxt) begin
      acc <= acc + {8'd0, r_q, g_q, b_q};
    end
`else
  assign frame_sum = '0;
`endif
endmodule

// File: tb/tb_vga_timing_decoder.sv
// tb_vga_timing_decoder: randomized raster stimulus checked against a sample-level reference model.
module tb_vga_timing_decoder;
  localparam int HV = 16, HF = 3, HS = 4, HB = 5;
  localparam int VV = 6, VF = 2, VS = 2, VB = 3;
  localparam int LF = 2;
  localparam int HT = HV + HF + HS + HB, VT = VV + VF + VS + VB;
  localparam int HX0 = HS + HB, VY0 = VS + VB;
  logic clk = 0, rst = 1, h_sync = 1, v_sync = 1;
  logic [7:0] red = 0, green = 0, blue = 0;
  logic pixel_valid, line_start, frame_start, locked, h_err, v_err;
  logic [9:0] x, y;
  logic [7:0] pix_r, pix_g, pix_b;
  logic [31:0] frame_sum;
  always #5 clk = ~clk;
  vga_timing_decoder #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(1'b0), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .rst(rst), .h_sync(h_sync), .v_sync(v_sync),
    .red(red), .green(green), .blue(blue),
    .pixel_valid(pixel_valid), .x(x), .y(y),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .line_start(line_start), .frame_start(frame_start), .locked(locked),
    .h_err(h_err), .v_err(v_err), .frame_sum(frame_sum)
  );
  typedef struct {
    logic pv, ls, fs, lk, he, ve, cm;
    logic [9:0] x, y;
    logic [7:0] r, g, b;
    logic [31:0] fsum;
  } exp_t;
  exp_t q[$];
  int n_tests = 0, n_fail = 0;
  int m_h, m_v, m_st, m_good;
  bit m_hp, m_vp, m_pend, m_full;
  logic [9:0] m_x, m_y;
  logic [7:0] m_r, m_g, m_b;
  logic [31:0] m_acc, m_fsum;
  int cnt_he = 0, cnt_ve = 0, pv_cnt = 0, max_x = 0, max_y = 0;
  bit fs_seen = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_h = 0; m_v = 0; m_st = 0; m_good = 0;
    m_hp = 0; m_vp = 0; m_pend = 0; m_full = 0;
    m_x = 0; m_y = 0; m_r = 0; m_g = 0; m_b = 0;
    m_acc = 0; m_fsum = 0;
    fs_seen = 0;
  endtask
  // m_st: 0 = searching, 1 = tracking, 2 = locked
  task automatic model(input bit hs_a, input bit vs_a, input logic [7:0] r, g, b, input bit cm);
    exp_t e;
    bit he, ve, on, herr, verr, vis;
    he = hs_a && !m_hp;
    ve = vs_a && !m_vp;
    m_hp = hs_a;
    m_vp = vs_a;
    on = m_st != 0;
    herr = 0;
    verr = 0;
    if (ve && on && m_v != VT - 1) verr = 1;
    if (he) begin
      if (on && m_h != HT - 1) herr = 1;
      m_h = 0;
      if (m_pend || ve) begin
        m_v = 0;
        m_pend = 0;
      end else if (m_v < VT) begin
        m_v++;
        if (on && m_v == VT) verr = 1;
      end
    end else begin
      if (m_h < HT) begin
        m_h++;
        if (on && m_h == HT) herr = 1;
      end
      if (ve) m_pend = 1;
    end
    if (m_st == 0) begin
      if (ve) begin m_st = 1; m_good = 0; end
    end else if (herr || verr) m_st = 0;
    else if (m_st == 1 && ve) begin
      m_good++;
      if (m_good == LF) m_st = 2;
    end
    vis = m_st == 2 && m_h >= HX0 && m_h < HX0 + HV && m_v >= VY0 && m_v < VY0 + VV;
    e.pv = vis;
    e.ls = vis && m_h == HX0;
    e.fs = e.ls && m_v == VY0;
    e.lk = m_st == 2;
    e.he = herr;
    e.ve = verr;
    e.cm = cm;
    if (vis) begin
      m_x = 10'(m_h - HX0);
      m_y = 10'(m_v - VY0);
      m_r = r; m_g = g; m_b = b;
    end
`ifdef VGA_DEC_CHECKSUM_EN
    if (m_st != 2) begin
      m_acc = 0;
      m_full = 0;
    end else if (e.fs) begin
      if (m_full) m_fsum = m_acc;
      m_acc = {8'd0, r, g, b};
      m_full = 1;
    end else if (vis) m_acc = m_acc + {8'd0, r, g, b};
`endif
    e.x = m_x; e.y = m_y; e.r = m_r; e.g = m_g; e.b = m_b;
    e.fsum = m_fsum;
    q.push_back(e);
  endtask
  task automatic step(input bit hs_a, input bit vs_a, input logic [7:0] r, g, b, input bit cm);
    exp_t e;
    if (q.size() >= 2) begin
      e = q.pop_front();
      chk("pixel_valid", pixel_valid, e.pv);
      chk("line_start", line_start, e.ls);
      chk("frame_start", frame_start, e.fs);
      chk("locked", locked, e.lk);
      chk("h_err", h_err, e.he);
      chk("v_err", v_err, e.ve);
      chk("xy", {x, y}, {e.x, e.y});
      chk("pix", {pix_r, pix_g, pix_b}, {e.r, e.g, e.b});
      chk("frame_sum", frame_sum, e.fsum);
      cnt_he += int'(h_err);
      cnt_ve += int'(v_err);
      if (h_err) chk("lock_drop_h", locked, 0);
      if (line_start) chk("ls_x", x, 0);
      if (frame_start) begin
        chk("fs_xy", {x, y}, 0);
        if (fs_seen) chk("pv_per_frame", pv_cnt, HV * VV);
        pv_cnt = 0;
        fs_seen = 1;
      end
      if (!locked) fs_seen = 0;
      if (pixel_valid) begin
        pv_cnt++;
        if (e.cm) begin
          chk("coord_r", pix_r, 8'(int'(x) + HX0));
          chk("coord_g", pix_g, 8'(int'(y) + VY0));
          if (int'(x) > max_x) max_x = int'(x);
          if (int'(y) > max_y) max_y = int'(y);
        end
      end
    end
    h_sync = !hs_a;
    v_sync = !vs_a;
    red = r; green = g; blue = b;
    model(hs_a, vs_a, r, g, b, cm);
    @(negedge clk);
  endtask
  task automatic do_reset(input int n);
    rst = 1;
    #1;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      chk("rst_ctl", {pixel_valid, line_start, frame_start, locked, h_err, v_err}, 0);
      chk("rst_data", {x, y, pix_r, pix_g, pix_b}, 0);
      chk("rst_sum", frame_sum, 0);
    end
    @(negedge clk);
    rst = 0;
    model_reset();
    q.delete();
  endtask
  // mode 0 random colour, 1 colour encodes raster position, 2 constant 0x010203
  task automatic run_frame(input int mode, input int short_ln, input bit drop_v, input int rst_ln);
    for (int gv = 0; gv < VT; gv++) begin
      int len;
      len = (gv == short_ln) ? HT - 1 : HT;
      for (int gh = 0; gh < len; gh++) begin
        logic [7:0] r, g, b;
        if (gv == rst_ln && gh == HX0 + 3) do_reset(3);
        r = mode == 1 ? 8'(gh) : mode == 2 ? 8'h01 : 8'($urandom);
        g = mode == 1 ? 8'(gv) : mode == 2 ? 8'h02 : 8'($urandom);
        b = mode == 1 ? 8'h5A : mode == 2 ? 8'h03 : 8'($urandom);
        step(gh < HS, gv < VS && !drop_v, r, g, b, mode == 1);
      end
    end
  endtask
  initial begin
    model_reset();
    @(negedge clk);
    do_reset(3);
    for (int f = 0; f < 5; f++) run_frame(0, -1, 0, -1);
    chk("locked_after_lock", locked, 1);
    for (int f = 0; f < 2; f++) run_frame(1, -1, 0, -1);
    chk("last_x", max_x, HV - 1);
    chk("last_y", max_y, VV - 1);
    run_frame(0, int'($urandom_range(0, VT - 1)), 0, -1);
    for (int f = 0; f < 5; f++) run_frame(0, -1, 0, -1);
    chk("h_err_pulses", cnt_he, 1);
    chk("locked_after_h", locked, 1);
    run_frame(0, -1, 1, -1);
    for (int f = 0; f < 5; f++) run_frame(0, -1, 0, -1);
    chk("v_err_pulses", cnt_ve, 1);
    chk("h_err_after_v", cnt_he, 1);
    chk("locked_after_v", locked, 1);
    run_frame(0, -1, 0, VY0 + 3);
    for (int f = 0; f < 4; f++) run_frame(0, -1, 0, -1);
    chk("locked_after_rst", locked, 1);
    for (int f = 0; f < 3; f++) run_frame(2, -1, 0, -1);
`ifdef VGA_DEC_CHECKSUM_EN
    chk("frame_sum_const", frame_sum, 32'(HV * VV * 32'h010203));
`else
    chk("frame_sum_off", frame_sum, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
